// File: rtl/fcs_appender_pkg.sv
// rtl/fcs_appender_pkg.sv - shared types, defaults and CRC step for fcs_appender
package fcs_appender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY     = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_CRC_INIT = 32'hFFFFFFFF;
  localparam int          FCS_LEN          = 32;

  // One serial CRC-32 step, MSB-first register, bit 31 feedback.
  function automatic logic [31:0] crc32_step(input logic [31:0] cur,
                                             input logic [31:0] poly,
                                             input logic        din);
    return {cur[30:0], 1'b0} ^ (poly & {32{din ^ cur[31]}});
  endfunction

endpackage

// File: rtl/fcs_appender_if.sv
// rtl/fcs_appender_if.sv - serial payload in / framed bit stream out handshake bundle
interface fcs_appender_if;
  logic s_valid;
  logic s_in;
  logic s_last;
  logic s_ready;
  logic m_valid;
  logic m_out;
  logic m_last;

  modport slave (
    input  s_valid, s_in, s_last,
    output s_ready, m_valid, m_out, m_last
  );

  modport master (
    output s_valid, s_in, s_last,
    input  s_ready, m_valid, m_out, m_last
  );
endinterface

// File: rtl/crc32_serial_lfsr.sv
// rtl/crc32_serial_lfsr.sv - bit-serial CRC-32 register with synchronous load
module crc32_serial_lfsr
  import fcs_appender_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_POLY,
  parameter logic [31:0] INIT = DEFAULT_CRC_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic        din,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else if (load) begin
      state <= INIT;
    end else if (shift) begin
      state <= crc32_step(state, POLY, din);
    end
  end

endmodule

// File: rtl/fcs_appender.sv
// rtl/fcs_appender.sv - echoes a serial payload and appends its 32-bit CRC, MSB first
// FCS_INVERT_EN: when defined, the appended FCS is the ones-complement of the CRC register.
module fcs_appender
  import fcs_appender_pkg::*;
#(
  parameter logic [31:0] POLY     = DEFAULT_POLY,
  parameter logic [31:0] CRC_INIT = DEFAULT_CRC_INIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  fcs_appender_if.slave        bus,
  output logic                 busy,
  output logic [31:0]          crc
);

  localparam logic [4:0] LAST_CNT = 5'(FCS_LEN - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic        m_valid_q;
  logic        m_out_q;
  logic        m_last_q;
  logic        accept;
  logic        load;
  logic [31:0] fcs_word;

  assign accept      = bus.s_valid && (state == DATA);
  assign load        = start && (state == IDLE);
  assign bus.s_ready = (state == DATA);
  assign bus.m_valid = m_valid_q;
  assign bus.m_out   = m_out_q;
  assign bus.m_last  = m_last_q;
  assign busy        = (state != IDLE);

`ifdef FCS_INVERT_EN
  assign fcs_word = ~crc;
`else
  assign fcs_word = crc;
`endif

  crc32_serial_lfsr #(
    .POLY (POLY),
    .INIT (CRC_INIT)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (accept),
    .din   (bus.s_in),
    .state (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      m_valid_q <= 1'b0;
      m_out_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      m_out_q   <= 1'b0;
      m_last_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= DATA;
        end
        DATA: begin
          if (accept) begin
            m_valid_q <= 1'b1;
            m_out_q   <= bus.s_in;
            if (bus.s_last) begin
              state <= FCS;
              cnt   <= 5'd0;
            end
          end
        end
        FCS: begin
          // ~cnt == 31 - cnt, so the frozen CRC goes out MSB first.
          m_valid_q <= 1'b1;
          m_out_q   <= fcs_word[~cnt];
          m_last_q  <= (cnt == LAST_CNT);
          cnt       <= cnt + 5'd1;
          if (cnt == LAST_CNT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
